seg_display_scan: RTL and testbench

Parametrised successor to the fixed 4-digit segment driver. It multiplexes NUM_DIGITS active-low seven-segment digits (with decimal point) from one clock. It adds:
- a sequential binary-to-BCD converter (iterative double-dabble), so there are no divide/modulo operators,
- a programmable scan rate,
- leading-zero blanking, whole-display blink, and overflow saturation.

It sits between game control (mode, move counter, text patterns) and the board's seg/an pins.

---
 rtl/seg_display_scan.sv | 231 +++++++++++++++++++++++
 tb/tb_seg_display_scan.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_scan.sv
// Multiplexed active-low seven-segment driver for NUM_DIGITS digits with a
// sequential double-dabble converter, programmable scan rate, blanking and blink.
module seg_display_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int VALUE_W    = 14,
  parameter int SCAN_DIV   = 1,
  parameter int BLINK_DIV  = 64
) (
  input  logic                    segclk,
  input  logic                    rst,
  input  logic [1:0]              mode,
  input  logic [8*NUM_DIGITS-1:0] text,
  input  logic [VALUE_W-1:0]      value,
  input  logic                    blank_lz,
  input  logic                    blink,
  output logic                    overflow,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int CNT_W = $clog2(VALUE_W + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int k = 0; k < n; k++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0]      MAX_VAL   = pow10(NUM_DIGITS) - 64'd1;
  localparam logic [BCD_W-1:0] ALL_NINES = {NUM_DIGITS{4'h9}};

  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Binary-to-BCD converter
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {CONV_LOAD, CONV_SHIFT, CONV_DONE} conv_state_t;

  conv_state_t        state_reg, state_next;
  logic [VALUE_W-1:0] cap_reg, cap_next;
  logic [VALUE_W-1:0] bin_reg, bin_next;
  logic [BCD_W-1:0]   bcd_reg, bcd_next;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   disp_reg, disp_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               overflow_reg, overflow_next;
  logic               cap_over;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                  bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
    end
  endgenerate

  // Overflow is judged on the captured binary, since the truncated BCD
  // accumulator cannot represent values beyond NUM_DIGITS digits.
  assign cap_over = 64'(cap_reg) > MAX_VAL;

  always_comb begin
    state_next    = state_reg;
    cap_next      = cap_reg;
    bin_next      = bin_reg;
    bcd_next      = bcd_reg;
    cnt_next      = cnt_reg;
    disp_next     = disp_reg;
    overflow_next = overflow_reg;
    case (state_reg)
      CONV_LOAD: begin
        cap_next   = value;
        bin_next   = value;
        bcd_next   = '0;
        cnt_next   = '0;
        state_next = CONV_SHIFT;
      end
      CONV_SHIFT: begin
        {bcd_next, bin_next} = {bcd_adj, bin_reg} << 1;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CNT_W'(VALUE_W - 1)) state_next = CONV_DONE;
      end
      CONV_DONE: begin
        if (cap_over) begin
          disp_next     = ALL_NINES;
          overflow_next = 1'b1;
        end else begin
          disp_next     = bcd_reg;
          overflow_next = 1'b0;
        end
        state_next = CONV_LOAD;
      end
      default: state_next = CONV_LOAD;
    endcase
  end

  always_ff @(posedge segclk or posedge rst) begin
    if (rst) begin
      state_reg    <= CONV_LOAD;
      cap_reg      <= '0;
      bin_reg      <= '0;
      bcd_reg      <= '0;
      cnt_reg      <= '0;
      disp_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cap_reg      <= cap_next;
      bin_reg      <= bin_next;
      bcd_reg      <= bcd_next;
      cnt_reg      <= cnt_next;
      disp_reg     <= disp_next;
      overflow_reg <= overflow_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-digit pattern selection
  // ---------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0][7:0] pat;
  logic [NUM_DIGITS-1:0]      lead_zero;

  // lead_zero[i]: digit i and everything to its left are zero.
  always_comb begin
    lead_zero    = '0;
    lead_zero[0] = (disp_reg[BCD_W-1 -: 4] == 4'd0);
    for (int k = 1; k < NUM_DIGITS; k++) begin
      lead_zero[k] = lead_zero[k-1] & (disp_reg[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
    end
  end

  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_pat
      localparam bit IS_LAST = (gi == NUM_DIGITS - 1);
      logic [3:0] nib;
      logic       lz_blank;
      assign nib      = disp_reg[4*(NUM_DIGITS-1-gi) +: 4];
      assign lz_blank = blank_lz && lead_zero[gi] && !IS_LAST;
      assign pat[gi]  = (mode == 2'd0) ? text[8*(NUM_DIGITS-1-gi) +: 8] :
                        (mode == 2'd1) ? (lz_blank ? 8'hFF : seg_decode(nib)) :
                        (mode == 2'd2) ? 8'h7F : 8'hFF;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Scan, blink and output registers
  // ---------------------------------------------------------------------------
  logic [PRE_W-1:0]      pre_reg, pre_next;
  logic [IDX_W-1:0]      idx_reg, idx_next;
  logic [BLK_W-1:0]      blk_cnt_reg, blk_cnt_next;
  logic                  phase_on_reg, phase_on_next;
  logic [7:0]            seg_reg, seg_next;
  logic [NUM_DIGITS-1:0] an_reg, an_next;
  logic [NUM_DIGITS-1:0] an_slot;
  logic                  advance;
  logic                  wrap;

  assign advance = (pre_reg == PRE_W'(SCAN_DIV - 1));
  assign wrap    = advance && (idx_reg == IDX_W'(NUM_DIGITS - 1));
  assign an_slot = NUM_DIGITS'(1) << (IDX_W'(NUM_DIGITS - 1) - idx_reg);

  // idx_reg names the slot loaded at the next advance, so the first pattern
  // shown after reset is digit 0.
  always_comb begin
    pre_next      = advance ? '0 : pre_reg + 1'b1;
    idx_next      = idx_reg;
    seg_next      = seg_reg;
    an_next       = an_reg;
    blk_cnt_next  = blk_cnt_reg;
    phase_on_next = phase_on_reg;
    if (advance) begin
      seg_next = pat[idx_reg];
      an_next  = (blink && !phase_on_reg) ? '1 : ~an_slot;
      idx_next = wrap ? '0 : idx_reg + 1'b1;
    end
    if (!blink) begin
      blk_cnt_next  = '0;
      phase_on_next = 1'b1;
    end else if (wrap) begin
      if (blk_cnt_reg == BLK_W'(BLINK_DIV - 1)) begin
        blk_cnt_next  = '0;
        phase_on_next = ~phase_on_reg;
      end else begin
        blk_cnt_next = blk_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge segclk or posedge rst) begin
    if (rst) begin
      pre_reg      <= '0;
      idx_reg      <= '0;
      blk_cnt_reg  <= '0;
      phase_on_reg <= 1'b1;
      seg_reg      <= 8'hFF;
      an_reg       <= '1;
    end else begin
      pre_reg      <= pre_next;
      idx_reg      <= idx_next;
      blk_cnt_reg  <= blk_cnt_next;
      phase_on_reg <= phase_on_next;
      seg_reg      <= seg_next;
      an_reg       <= an_next;
    end
  end

  assign seg      = seg_reg;
  assign an       = an_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_seg_display_scan.sv
// Bench for seg_display_scan: directed and random scans compared against a
// decimal-arithmetic reference of what each digit slot should display.
module tb_seg_display_scan;

  localparam int ND = 4;

  logic          segclk;
  logic          rst;
  logic [1:0]    mode;
  logic [8*ND-1:0] text;
  logic [13:0]   value;
  logic          blank_lz;
  logic          blink;
  logic          overflow1, overflow3;
  logic [7:0]    seg1, seg3;
  logic [ND-1:0] an1, an3;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] seg_code [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  seg_display_scan #(.NUM_DIGITS(ND), .VALUE_W(14), .SCAN_DIV(1), .BLINK_DIV(2)) dut1 (
    .segclk(segclk), .rst(rst), .mode(mode), .text(text), .value(value),
    .blank_lz(blank_lz), .blink(blink), .overflow(overflow1), .seg(seg1), .an(an1)
  );

  seg_display_scan #(.NUM_DIGITS(ND), .VALUE_W(14), .SCAN_DIV(3), .BLINK_DIV(2)) dut3 (
    .segclk(segclk), .rst(rst), .mode(mode), .text(text), .value(value),
    .blank_lz(blank_lz), .blink(blink), .overflow(overflow3), .seg(seg3), .an(an3)
  );

  initial segclk = 1'b0;
  always #5 segclk = ~segclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // What digit slot idx (0 = leftmost) should show, from decimal arithmetic.
  function automatic logic [7:0] model_pat(input int idx, input int val);
    int place;
    place = 1;
    for (int k = 0; k < ND - 1 - idx; k++) place = place * 10;
    case (mode)
      2'd0: return text[8*(ND-1-idx) +: 8];
      2'd1: begin
        if (val > 9999) return 8'h90;
        if (blank_lz && idx != ND - 1 && val < place) return 8'hFF;
        return seg_code[(val / place) % 10];
      end
      2'd2: return 8'h7F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [ND-1:0] exp_an(input int idx);
    logic [ND-1:0] r;
    r = '1;
    r[ND-1-idx] = 1'b0;
    return r;
  endfunction

  // Slot index from an active-low anode vector; -1 unless exactly one is low.
  function automatic int an_to_idx(input logic [ND-1:0] a);
    int zeros, pos;
    zeros = 0;
    pos = 0;
    for (int b = 0; b < ND; b++) if (a[b] === 1'b0) begin zeros++; pos = b; end
    return (zeros == 1) ? (ND - 1 - pos) : -1;
  endfunction

  task automatic tick();
    @(posedge segclk);
    #1;
  endtask

  // One full scan on the SCAN_DIV=1 instance.
  task automatic scan_check(input string tag);
    int idx;
    tick();
    idx = an_to_idx(an1);
    check({tag, "/onehot"}, 32'(idx >= 0), 32'd1);
    if (idx < 0) idx = 0;
    check({tag, "/overflow"}, 32'(overflow1), 32'(int'(value) > 9999));
    for (int s = 0; s < ND; s++) begin
      if (s > 0) begin
        tick();
        idx = (idx + 1) % ND;
        check({tag, "/an"}, 32'(an1), 32'(exp_an(idx)));
      end
      check({tag, "/seg"}, 32'(seg1), 32'(model_pat(idx, int'(value))));
    end
    $display("scan %s mode=%0d value=%0d blank_lz=%0d", tag, mode, value, blank_lz);
  endtask

  // Wait (bounded) for an3 to change, i.e. the first cycle of a new slot.
  task automatic wait_slot3(input string tag, output int idx);
    logic [ND-1:0] prev;
    bit seen;
    prev = an3;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      if (an3 !== prev) seen = 1;
    end
    check({tag, "/slot_edge"}, 32'(seen), 32'd1);
    idx = an_to_idx(an3);
    if (idx < 0) idx = 0;
  endtask

  initial begin
    int idx;
    bit found;
    logic [7:0] old_pat;

    rst = 1'b1; mode = 2'd1; text = '0; value = 14'd1234; blank_lz = 1'b0; blink = 1'b0;
    repeat (3) tick();
    check("reset/seg1", 32'(seg1), 32'hFF);
    check("reset/an1", 32'(an1), 32'hF);
    check("reset/ovf1", 32'(overflow1), 32'd0);
    check("reset/seg3", 32'(seg3), 32'hFF);
    check("reset/an3", 32'(an3), 32'hF);
    rst = 1'b0;

    // number display
    repeat (40) tick();
    scan_check("num1234");
    value = 14'd7; blank_lz = 1'b1;
    repeat (40) tick();
    scan_check("num7_lz");
    value = 14'd0;
    repeat (40) tick();
    scan_check("num0_lz");
    value = 14'd12000;
    repeat (40) tick();
    scan_check("ovf_lz");
    blank_lz = 1'b0;
    scan_check("ovf");

    // random mixes of mode, text, value and blanking
    for (int r = 0; r < 8; r++) begin
      mode     = 2'($urandom_range(0, 3));
      text     = $urandom;
      value    = 14'($urandom_range(0, 16383) >> $urandom_range(0, 13));
      blank_lz = 1'($urandom_range(0, 1));
      repeat (40) tick();
      scan_check($sformatf("rand%0d", r));
    end

    // text mode on the SCAN_DIV=3 instance: every slot exactly 3 cycles
    mode = 2'd0; text = 32'hC6C18086;
    wait_slot3("text3", idx);
    for (int k = 0; k < ND; k++) begin
      for (int c = 0; c < 3; c++) begin
        if (k > 0 || c > 0) tick();
        check("text3/an", 32'(an3), 32'(exp_an(idx)));
        check("text3/seg", 32'(seg3), 32'(model_pat(idx, int'(value))));
      end
      idx = (idx + 1) % ND;
    end
    $display("scan text3 div=3 text=%h", text);

    // dots take effect only at the next advance
    wait_slot3("dots3", idx);
    old_pat = model_pat(idx, int'(value));
    mode = 2'd2;
    for (int c = 1; c < 3; c++) begin
      tick();
      check("dots3/hold", 32'(seg3), 32'(old_pat));
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      check("dots3/seg", 32'(seg3), 32'h7F);
    end
    $display("scan dots3 held=%h", old_pat);

    // blink with BLINK_DIV=2: 8 cycles dark, 8 lit, seg keeps scanning
    mode = 2'd1; value = 14'd1234; blank_lz = 1'b0;
    repeat (40) tick();
    blink = 1'b1;
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      tick();
      if (an1 === 4'hF) found = 1;
    end
    check("blink/start", 32'(found), 32'd1);
    for (int c = 0; c < 36; c++) begin
      if (c > 0) tick();
      check("blink/an", 32'(an1), ((c % 16) < 8) ? 32'hF : 32'(exp_an(c % ND)));
      check("blink/seg", 32'(seg1), 32'(model_pat(c % ND, int'(value))));
    end
    blink = 1'b0;
    tick();
    check("blink/resume", 32'(an_to_idx(an1) >= 0), 32'd1);
    $display("scan blink div=2 dropped");

    // reset in the middle of a conversion
    value = 14'd12000;
    repeat (40) tick();
    check("rstmid/ovf_before", 32'(overflow1), 32'd1);
    value = 14'd9999;
    repeat (5) tick();
    check("rstmid/ovf_pending", 32'(overflow1), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rstmid/seg", 32'(seg1), 32'hFF);
    check("rstmid/an", 32'(an1), 32'hF);
    check("rstmid/ovf", 32'(overflow1), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("rstmid/first_an", 32'(an1), 32'(exp_an(0)));
    check("rstmid/first_seg", 32'(seg1), 32'(model_pat(0, 0)));
    repeat (26) tick();
    scan_check("after_rst9999");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
